wb_stage_q: RTL and testbench

- Parametrised writeback stage for the CPU datapath.
- Each accepted instruction result is formatted at enqueue time. Sources are: ALU result, load data (byte/half/word with sign or zero extend), LUI immediate, AUIPC (PC+imm) and jump link (PC+4).
- Formatted results are buffered in a DEPTH-entry FIFO and retired to the register-file write port under a valid/ready handshake.
- Forwarding of the oldest pending write and a retired-write counter are also provided.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/wb_format.sv | 77 +++++++
 rtl/wb_stage_q.sv | 162 ++++++++++++++++
 tb/tb_wb_stage_q.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared CPU datapath definitions.
//   wb_sel_e  : writeback source select (ALU, MEM, LUI, AUIPC, LINK); codes
//               5-7 are reserved and mean "accept and discard".
//   ld_size_e : load access size (BYTE, HALF, WORD); code 3 behaves as WORD.
//   LINK_OFS  : return-address offset added to the PC for jump-and-link.
// ---------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [2:0] {
    WB_ALU   = 3'd0,
    WB_MEM   = 3'd1,
    WB_LUI   = 3'd2,
    WB_AUIPC = 3'd3,
    WB_LINK  = 3'd4
  } wb_sel_e;

  typedef enum logic [1:0] {
    LD_BYTE = 2'd0,
    LD_HALF = 2'd1,
    LD_WORD = 2'd2
  } ld_size_e;

  localparam int LINK_OFS = 4;

  // Codes above WB_LINK carry no result.
  function automatic logic sel_is_valid(input logic [2:0] sel);
    return sel <= 3'(WB_LINK);
  endfunction

endpackage

// File: rtl/wb_format.sv
// ---------------------------------------------------------------------------
// wb_format
// Purely combinational writeback result formatter: selects the result source
// and aligns/extends load data.  Kept separate so the load unit can reuse it.
// Ports:
//   i_sel   source select (wb_sel_e encoding, 5-7 reserved)
//   i_pc    instruction PC (zero-extended to XLEN)
//   i_imm   U-type immediate, already shifted
//   i_alu   ALU result
//   i_ramd  raw RAM word
//   i_ldsz  load size (ld_size_e, 3 treated as word)
//   i_ldu   1 = zero extend, 0 = sign extend
//   i_alo   load address low bits (byte lane)
//   o_data  formatted result (0 for reserved selects)
//   o_valid select carries a result
// ---------------------------------------------------------------------------
module wb_format
  import cpu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 12
) (
  input  logic [2:0]      i_sel,
  input  logic [PC_W-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_alu,
  input  logic [XLEN-1:0] i_ramd,
  input  logic [1:0]      i_ldsz,
  input  logic            i_ldu,
  input  logic [1:0]      i_alo,
  output logic [XLEN-1:0] o_data,
  output logic            o_valid
);

  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_byte_ext;
  logic [XLEN-1:0] w_half_ext;
  logic [XLEN-1:0] w_load;
  logic [PC_W-1:0] w_link_pc;
  logic [XLEN-1:0] w_auipc;

  // Lane select: byte lane = alo, half lane = alo[1] (alo[0] ignored).
  assign w_byte = i_ramd[{i_alo, 3'b000} +: 8];
  assign w_half = i_ramd[{i_alo[1], 4'b0000} +: 16];

  assign w_byte_ext = {{(XLEN-8){~i_ldu & w_byte[7]}}, w_byte};
  assign w_half_ext = {{(XLEN-16){~i_ldu & w_half[15]}}, w_half};

  // Link address wraps inside the PC width before zero extension.
  assign w_link_pc = i_pc + PC_W'(LINK_OFS);
  assign w_auipc   = {{(XLEN-PC_W){1'b0}}, i_pc} + i_imm;

  always_comb begin
    w_load = i_ramd;
    case (i_ldsz)
      LD_BYTE: w_load = w_byte_ext;
      LD_HALF: w_load = w_half_ext;
      default: w_load = i_ramd;
    endcase
  end

  always_comb begin
    o_data = '0;
    case (i_sel)
      WB_ALU:   o_data = i_alu;
      WB_MEM:   o_data = w_load;
      WB_LUI:   o_data = i_imm;
      WB_AUIPC: o_data = w_auipc;
      WB_LINK:  o_data = {{(XLEN-PC_W){1'b0}}, w_link_pc};
      default:  o_data = '0;
    endcase
  end

  assign o_valid = sel_is_valid(i_sel);

endmodule

// File: rtl/wb_stage_q.sv
// ---------------------------------------------------------------------------
// wb_stage_q
// Writeback stage: formats each accepted result at enqueue time, buffers it
// in a DEPTH-entry FIFO and retires entries to the register-file write port
// under a valid/ready handshake.  Also forwards the oldest pending write and
// counts retired writes.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   enqueue handshake (in_ready = not full)
//   in_rd, in_sel, in_pc, in_imm, in_alu, in_ramd, in_ldsz, in_ldu, in_alo
//                       instruction result fields (see wb_format)
//   rf_we/rf_ready      dequeue handshake to the register file
//   rf_waddr, rf_wdata  head entry (held while empty)
//   fwd_valid/rd/data   copy of the register-file write port
//   busy                FIFO non-empty
//   wb_count            retired writes, wraps at 2^CNT_W
// All outputs come from registers; no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module wb_stage_q
  import cpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int PC_W  = 12,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic [2:0]       in_sel,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  in_ramd,
  input  logic [1:0]       in_ldsz,
  input  logic             in_ldu,
  input  logic [1:0]       in_alo,
  output logic             rf_we,
  input  logic             rf_ready,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic             busy,
  output logic [CNT_W-1:0] wb_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [XLEN-1:0]  w_fmt_data;
  logic             w_fmt_valid;

  logic [4:0]       r_mem_rd   [DEPTH];
  logic [XLEN-1:0]  r_mem_data [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [CNT_W-1:0] r_wb_count;
  logic [4:0]       r_out_rd;
  logic [XLEN-1:0]  r_out_data;

  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_rptr_nx;
  logic [CW-1:0]    w_count_nx;
  logic             w_head_is_new;

  wb_format #(
    .XLEN (XLEN),
    .PC_W (PC_W)
  ) u_fmt (
    .i_sel   (in_sel),
    .i_pc    (in_pc),
    .i_imm   (in_imm),
    .i_alu   (in_alu),
    .i_ramd  (in_ramd),
    .i_ldsz  (in_ldsz),
    .i_ldu   (in_ldu),
    .i_alo   (in_alo),
    .o_data  (w_fmt_data),
    .o_valid (w_fmt_valid)
  );

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Full blocks acceptance even when a pop happens in the same cycle.
  assign w_accept = in_valid & ~w_full;
  // rd==0 and reserved selects are consumed without creating an entry.
  assign w_push   = w_accept & w_fmt_valid & (in_rd != 5'd0);
  assign w_pop    = ~w_empty & rf_ready;

  assign w_rptr_nx = w_pop ? r_rptr + AW'(1) : r_rptr;

  always_comb begin
    w_count_nx = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nx = r_count + CW'(1);
      2'b01:   w_count_nx = r_count - CW'(1);
      default: w_count_nx = r_count;
    endcase
  end

  // The pushed entry becomes the head only if nothing else remains after
  // this cycle's pop.
  assign w_head_is_new = w_push & (r_count == CW'(w_pop));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wptr]   <= in_rd;
      r_mem_data[r_wptr] <= w_fmt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_wb_count <= '0;
      r_out_rd   <= '0;
      r_out_data <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      r_rptr  <= w_rptr_nx;
      r_count <= w_count_nx;
      if (w_pop) begin
        r_wb_count <= r_wb_count + CNT_W'(1);
      end
      // Registered head copy; holds the last value once the FIFO drains.
      if (w_count_nx != '0) begin
        if (w_head_is_new) begin
          r_out_rd   <= in_rd;
          r_out_data <= w_fmt_data;
        end else begin
          r_out_rd   <= r_mem_rd[w_rptr_nx];
          r_out_data <= r_mem_data[w_rptr_nx];
        end
      end
    end
  end

  assign in_ready  = ~w_full;
  assign rf_we     = ~w_empty;
  assign rf_waddr  = r_out_rd;
  assign rf_wdata  = r_out_data;
  assign fwd_valid = rf_we;
  assign fwd_rd    = r_out_rd;
  assign fwd_data  = r_out_data;
  assign busy      = ~w_empty;
  assign wb_count  = r_wb_count;

endmodule

// File: tb/tb_wb_stage_q.sv
module tb_wb_stage_q;

  localparam int XLEN  = 32;
  localparam int PC_W  = 12;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_rd;
  logic [2:0]       in_sel;
  logic [PC_W-1:0]  in_pc;
  logic [XLEN-1:0]  in_imm;
  logic [XLEN-1:0]  in_alu;
  logic [XLEN-1:0]  in_ramd;
  logic [1:0]       in_ldsz;
  logic             in_ldu;
  logic [1:0]       in_alo;
  logic             rf_we;
  logic             rf_ready;
  logic [4:0]       rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
  logic             fwd_valid;
  logic [4:0]       fwd_rd;
  logic [XLEN-1:0]  fwd_data;
  logic             busy;
  logic [CNT_W-1:0] wb_count;

  always #5 clk = ~clk;

  wb_stage_q #(.XLEN(XLEN), .PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_sel(in_sel), .in_pc(in_pc), .in_imm(in_imm),
    .in_alu(in_alu), .in_ramd(in_ramd), .in_ldsz(in_ldsz), .in_ldu(in_ldu),
    .in_alo(in_alo), .rf_we(rf_we), .rf_ready(rf_ready), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .busy(busy), .wb_count(wb_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: a plain queue of pending writes plus the last shown head.
  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t        m_q[$];
  logic [4:0]  m_rd_shown;
  logic [31:0] m_data_shown;
  logic [15:0] m_cnt;

  typedef struct {
    logic [2:0]  sel;
    logic [4:0]  rd;
    logic [11:0] pc;
    logic [31:0] imm;
    logic [31:0] alu;
    logic [31:0] ramd;
    logic [1:0]  ldsz;
    logic        ldu;
    logic [1:0]  alo;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Formatting rules expressed with integer arithmetic.
  function automatic logic [31:0] ref_fmt(input logic [2:0] sel, input logic [11:0] pc,
                                          input logic [31:0] imm, input logic [31:0] alu,
                                          input logic [31:0] ramd, input logic [1:0] ldsz,
                                          input logic ldu, input logic [1:0] alo);
    longint unsigned v;
    case (sel)
      3'd0: return alu;
      3'd2: return imm;
      3'd3: begin
        v = (longint'(pc) + longint'(imm)) % 64'h1_0000_0000;
        return v[31:0];
      end
      3'd4: begin
        v = (longint'(pc) + 4) % 4096;
        return v[31:0];
      end
      3'd1: begin
        if (ldsz == 2'd0) begin
          v = (longint'(ramd) / (64'd1 << (8 * alo))) % 256;
          if (!ldu && v >= 128) v = v + 64'hFFFF_FF00;
          return v[31:0];
        end else if (ldsz == 2'd1) begin
          v = (longint'(ramd) / (alo >= 2 ? 64'd65536 : 64'd1)) % 65536;
          if (!ldu && v >= 32768) v = v + 64'hFFFF_0000;
          return v[31:0];
        end
        return ramd;
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_check(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_q.size() < DEPTH));
    chk({tag, ".rf_we"},    32'(rf_we),    32'(m_q.size() > 0));
    chk({tag, ".busy"},     32'(busy),     32'(m_q.size() > 0));
    chk({tag, ".fwd_v"},    32'(fwd_valid), 32'(m_q.size() > 0));
    chk({tag, ".waddr"},    32'(rf_waddr), 32'(m_rd_shown));
    chk({tag, ".wdata"},    rf_wdata,      m_data_shown);
    chk({tag, ".fwd_rd"},   32'(fwd_rd),   32'(m_rd_shown));
    chk({tag, ".fwd_data"}, fwd_data,      m_data_shown);
    chk({tag, ".wb_count"}, 32'(wb_count), 32'(m_cnt));
  endtask

  // One clock: model decides from pre-edge inputs, DUT clocks, then compare.
  task automatic cycle(input string tag);
    bit   acc, keep, pop;
    ent_t e;
    acc  = in_valid && (m_q.size() < DEPTH);
    keep = (in_rd != 0) && (in_sel <= 3'd4);
    pop  = (m_q.size() > 0) && rf_ready;
    e.rd   = in_rd;
    e.data = ref_fmt(in_sel, in_pc, in_imm, in_alu, in_ramd, in_ldsz, in_ldu, in_alo);
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_rd_shown   = '0;
      m_data_shown = '0;
      m_cnt        = '0;
    end else begin
      if (pop) begin
        void'(m_q.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (acc && keep) m_q.push_back(e);
      if (m_q.size() > 0) begin
        m_rd_shown   = m_q[0].rd;
        m_data_shown = m_q[0].data;
      end
    end
    @(negedge clk);
    model_check(tag);
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [2:0] sel,
                       input logic [11:0] pc, input logic [31:0] imm, input logic [31:0] alu,
                       input logic [31:0] ramd, input logic [1:0] ldsz, input logic ldu,
                       input logic [1:0] alo);
    in_valid = v; in_rd = rd; in_sel = sel; in_pc = pc; in_imm = imm;
    in_alu = alu; in_ramd = ramd; in_ldsz = ldsz; in_ldu = ldu; in_alo = alo;
  endtask

  task automatic push_alu(input logic [4:0] rd, input logic [31:0] val);
    drive(1'b1, rd, 3'd0, 12'h0, 32'h0, val, 32'h0, 2'd2, 1'b0, 2'd0);
  endtask

  logic [15:0] cnt_before;

  initial begin
    vecs[0]  = '{3'd0, 5'd5,  12'h000, 32'h0,        32'h1234, 32'h0,        2'd2, 1'b0, 2'd0, 32'h0000_1234};
    vecs[1]  = '{3'd4, 5'd1,  12'hFFC, 32'h0,        32'h0,    32'h0,        2'd2, 1'b0, 2'd0, 32'h0000_0000};
    vecs[2]  = '{3'd3, 5'd2,  12'h010, 32'h2000,     32'h0,    32'h0,        2'd2, 1'b0, 2'd0, 32'h0000_2010};
    vecs[3]  = '{3'd1, 5'd3,  12'h000, 32'h0,        32'h0,    32'h80FF7F01, 2'd0, 1'b0, 2'd3, 32'hFFFF_FF80};
    vecs[4]  = '{3'd1, 5'd4,  12'h000, 32'h0,        32'h0,    32'h80FF7F01, 2'd0, 1'b1, 2'd3, 32'h0000_0080};
    vecs[5]  = '{3'd1, 5'd6,  12'h000, 32'h0,        32'h0,    32'h80FF7F01, 2'd1, 1'b0, 2'd2, 32'hFFFF_80FF};
    vecs[6]  = '{3'd1, 5'd7,  12'h000, 32'h0,        32'h0,    32'h80FF7F01, 2'd1, 1'b1, 2'd0, 32'h0000_7F01};
    vecs[7]  = '{3'd1, 5'd8,  12'h000, 32'h0,        32'h0,    32'h80FF7F01, 2'd0, 1'b0, 2'd1, 32'h0000_007F};
    vecs[8]  = '{3'd1, 5'd9,  12'h000, 32'h0,        32'h0,    32'h80FF7F01, 2'd3, 1'b0, 2'd1, 32'h80FF_7F01};
    vecs[9]  = '{3'd2, 5'd10, 12'h123, 32'hABCDE000, 32'h0,    32'h0,        2'd2, 1'b0, 2'd0, 32'hABCD_E000};
    vecs[10] = '{3'd1, 5'd11, 12'h000, 32'h0,        32'h0,    32'h80FF7F01, 2'd0, 1'b0, 2'd2, 32'hFFFF_FFFF};
    vecs[11] = '{3'd3, 5'd31, 12'hFFF, 32'hFFFF_F000, 32'h0,   32'h0,        2'd2, 1'b0, 2'd0, 32'hFFFF_FFFF};

    m_rd_shown = '0; m_data_shown = '0; m_cnt = '0;
    rst = 1'b1; rf_ready = 1'b0;
    drive(1'b0, 5'd0, 3'd0, 12'h0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    @(negedge clk);
    cycle("rst0");
    rst = 1'b0;
    cycle("post_rst");
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.rf_we", 32'(rf_we), 32'd0);

    // Table-driven formatting vectors, one push then drain each.
    rf_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].rd, vecs[i].sel, vecs[i].pc, vecs[i].imm, vecs[i].alu,
            vecs[i].ramd, vecs[i].ldsz, vecs[i].ldu, vecs[i].alo);
      cycle("vec_push");
      chk($sformatf("vec%0d.we", i), 32'(rf_we), 32'd1);
      chk($sformatf("vec%0d.waddr", i), 32'(rf_waddr), 32'(vecs[i].rd));
      chk($sformatf("vec%0d.wdata", i), rf_wdata, vecs[i].exp);
      in_valid = 1'b0;
      cycle("vec_pop");
    end
    chk("vec.wb_count", 32'(wb_count), 32'd12);

    // Full: two accepts, third held until after the first pop.
    rf_ready = 1'b0;
    push_alu(5'd1, 32'hAAAA_0001); cycle("full1");
    push_alu(5'd2, 32'hAAAA_0002); cycle("full2");
    chk("full.in_ready", 32'(in_ready), 32'd0);
    push_alu(5'd3, 32'hAAAA_0003); cycle("full3_held");
    chk("full.held_ready", 32'(in_ready), 32'd0);
    chk("full.head1", 32'(rf_waddr), 32'd1);
    rf_ready = 1'b1;
    cycle("full_pop1");
    chk("full.head2", 32'(rf_waddr), 32'd2);
    chk("full.ready_after_pop", 32'(in_ready), 32'd1);
    cycle("full_pop2_push3");
    chk("full.head3", 32'(rf_waddr), 32'd3);
    chk("full.head3_data", rf_wdata, 32'hAAAA_0003);
    in_valid = 1'b0;
    cycle("full_drain");
    chk("full.empty", 32'(rf_we), 32'd0);
    chk("full.hold_data", rf_wdata, 32'hAAAA_0003);

    // Discarded instructions: rd==0 and reserved select.
    cnt_before = wb_count;
    push_alu(5'd0, 32'h5555_5555); cycle("disc_rd0");
    chk("disc.rd0_we", 32'(rf_we), 32'd0);
    drive(1'b1, 5'd9, 3'd6, 12'h0, 32'h0, 32'h1, 32'h0, 2'd2, 1'b0, 2'd0); cycle("disc_sel6");
    chk("disc.sel6_we", 32'(rf_we), 32'd0);
    chk("disc.ready", 32'(in_ready), 32'd1);
    chk("disc.count", 32'(wb_count), 32'(cnt_before));

    // Reset with two pending entries.
    rf_ready = 1'b0;
    push_alu(5'd12, 32'h0BAD_0001); cycle("rst_p1");
    push_alu(5'd13, 32'h0BAD_0002); cycle("rst_p2");
    in_valid = 1'b0;
    rst = 1'b1; cycle("rst_mid");
    rst = 1'b0;
    chk("rstmid.we", 32'(rf_we), 32'd0);
    chk("rstmid.busy", 32'(busy), 32'd0);
    chk("rstmid.count", 32'(wb_count), 32'd0);
    chk("rstmid.wdata", rf_wdata, 32'd0);
    rf_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle("rstmid_idle");
    chk("rstmid.no_write", 32'(wb_count), 32'd0);

    // Randomised traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      rf_ready = ($urandom_range(0, 2) != 0);
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
            ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
            12'($urandom), $urandom, $urandom, $urandom,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
